// File: rtl/mem_write_arbiter_fifo.sv
// Merges NUM_CH write-request streams, each through its own FIFO,
// into one registered valid/ready request port.
module mem_write_arbiter_fifo #(
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 128,
  parameter int MASK_W   = 16,
  parameter int ARB_MODE = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*ADDR_W-1:0] in_addr,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*MASK_W-1:0] in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [MASK_W-1:0]        out_mask,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W + MASK_W;

  logic [ENT_W-1:0] mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] ne;

  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] gnt, cand;
  logic            gnt_vld, load;

  logic             out_valid_q, out_valid_d;
  logic [ENT_W-1:0] out_ent_q, out_ent_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             busy_q, busy_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ne[i]       = (cnt_q[i] != '0);
      in_ready[i] = !reset && (cnt_q[i] != CNT_W'(DEPTH));
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // RR scans from the channel after the last grant; fixed scans from ch0
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 1) cand = CH_W'(k);
      else cand = CH_W'((int'(rr_q) + 1 + k) % NUM_CH);
      if (!gnt_vld && ne[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
    load = gnt_vld && (!out_valid_q || out_ready);
    pop  = '0;
    if (load) pop[gnt] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ent_d   = out_ent_q;
    out_ch_d    = out_ch_q;
    rr_d        = rr_q;
    busy_d      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      busy_d      = busy_d || (cnt_d[i] != '0);
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_ent_d   = mem_q[gnt][rd_ptr_q[gnt]];
      out_ch_d    = gnt;
      rr_d        = gnt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    busy_d = busy_d || out_valid_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {in_addr[i*ADDR_W +: ADDR_W],
                                  in_data[i*DATA_W +: DATA_W],
                                  in_mask[i*MASK_W +: MASK_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q        <= CH_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_ent_q   <= '0;
      out_ch_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_ent_q   <= out_ent_d;
      out_ch_q    <= out_ch_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_ent_q[ENT_W-1 -: ADDR_W];
  assign out_data  = out_ent_q[MASK_W +: DATA_W];
  assign out_mask  = out_ent_q[MASK_W-1:0];
  assign out_ch    = out_ch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_write_arbiter_fifo.sv
// Directed bench: round-robin instance plus a fixed-priority
// instance of mem_write_arbiter_fifo sharing clock and reset.
module tb_mem_write_arbiter_fifo;

  logic clk, reset;

  logic [1:0]   in_valid, in_ready;
  logic [53:0]  in_addr;
  logic [255:0] in_data;
  logic [31:0]  in_mask;
  logic         out_valid, out_ready, busy;
  logic [26:0]  out_addr;
  logic [127:0] out_data;
  logic [15:0]  out_mask;
  logic [0:0]   out_ch;

  logic [1:0]   in_valid_f, in_ready_f;
  logic [53:0]  in_addr_f;
  logic [255:0] in_data_f;
  logic [31:0]  in_mask_f;
  logic         out_valid_f, out_ready_f, busy_f;
  logic [26:0]  out_addr_f;
  logic [127:0] out_data_f;
  logic [15:0]  out_mask_f;
  logic [0:0]   out_ch_f;

  int n_chk  = 0;
  int n_pass = 0;

  mem_write_arbiter_fifo #(.ARB_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_mask(out_mask),
    .out_ch(out_ch), .busy(busy)
  );

  mem_write_arbiter_fifo #(.ARB_MODE(1)) dut_f (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_f), .in_ready(in_ready_f),
    .in_addr(in_addr_f), .in_data(in_data_f), .in_mask(in_mask_f),
    .out_valid(out_valid_f), .out_ready(out_ready_f),
    .out_addr(out_addr_f), .out_data(out_data_f), .out_mask(out_mask_f),
    .out_ch(out_ch_f), .busy(busy_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 2'b11;
    in_valid_f = 2'b11;
    out_ready = 1'b1;
    out_ready_f = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++;
      if (in_ready !== 2'b00)
        $display("FAIL rst_in_ready: got %b want 00", in_ready);
      else n_pass++;
    end
    reset = 1'b0;
    in_valid = 2'b00;
    in_valid_f = 2'b00;
    #1;
    n_chk++;
    if (in_ready !== 2'b11 || in_ready_f !== 2'b11)
      $display("FAIL rel_in_ready: got %b/%b want 11/11", in_ready, in_ready_f);
    else n_pass++;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== 27'h0)
      $display("FAIL rel_idle: got v=%b b=%b a=%h want 0 0 0", out_valid, busy, out_addr);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_valid_f !== 1'b0)
      $display("FAIL rel_nothing_queued: got v=%b b=%b vf=%b want 0", out_valid, busy, out_valid_f);
    else n_pass++;
  endtask

  task automatic test_single();
    in_valid = 2'b10;
    in_addr[53:27] = 27'h100;
    in_data[255:128] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    in_mask[31:16] = 16'h00FF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 2'b00;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_e0: got v=%b b=%b want v=0 b=1", out_valid, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_addr !== 27'h100 || out_ch !== 1'b1)
      $display("FAIL single_e1: got v=%b a=%h ch=%b want 1 100 1", out_valid, out_addr, out_ch);
    else n_pass++;
    n_chk++;
    if (out_data !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA || out_mask !== 16'h00FF)
      $display("FAIL single_payload: got d=%h m=%h", out_data, out_mask);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_e2: got v=%b b=%b want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        n_chk++;
        if (in_ready[0] !== 1'b1)
          $display("FAIL fill_ready7: got %b want 1", in_ready[0]);
        else n_pass++;
      end
      in_valid = 2'b01;
      in_addr[26:0] = 27'h200 + 27'(k);
      @(posedge clk); #1;
    end
    n_chk++;
    if (in_ready[0] !== 1'b0 || out_valid !== 1'b1 || out_addr !== 27'h200)
      $display("FAIL fill_full: got r=%b v=%b a=%h want 0 1 200", in_ready[0], out_valid, out_addr);
    else n_pass++;
    in_addr[26:0] = 27'h209;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready[0] !== 1'b0 || out_addr !== 27'h200)
      $display("FAIL fill_reject: got r=%b a=%h want 0 200", in_ready[0], out_addr);
    else n_pass++;
    in_valid = 2'b00;
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_addr !== 27'h200 + 27'(j) || out_ch !== 1'b0)
        $display("FAIL drain_%0d: got v=%b a=%h want 1 %h", j, out_valid, out_addr, 27'h200 + 27'(j));
      else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL drain_end: got v=%b b=%b want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_rr();
    logic exp_ch;
    int cyc;
    in_valid = 2'b11;
    in_addr[26:0] = 27'h0A0;
    in_addr[53:27] = 27'h0B0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL rr_first: got v=%b want 0", out_valid);
    else n_pass++;
    exp_ch = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch ||
          out_addr !== (exp_ch ? 27'h0B0 : 27'h0A0))
        $display("FAIL rr_%0d: got v=%b ch=%b a=%h want 1 %b", j, out_valid, out_ch, out_addr, exp_ch);
      else n_pass++;
      exp_ch = ~exp_ch;
    end
    in_valid = 2'b00;
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++;
    if (busy !== 1'b0)
      $display("FAIL rr_drain_timeout: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_fixed();
    logic [26:0] ea;
    out_ready_f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_f = 2'b11;
      in_addr_f[26:0] = 27'h500 + 27'(k);
      in_addr_f[53:27] = 27'h600 + 27'(k);
      @(posedge clk); #1;
    end
    in_valid_f = 2'b00;
    out_ready_f = 1'b1;
    for (int j = 0; j < 8; j++) begin
      ea = (j < 4) ? 27'h500 + 27'(j) : 27'h600 + 27'(j - 4);
      n_chk++;
      if (out_valid_f !== 1'b1 || out_addr_f !== ea || out_ch_f !== 1'((j >= 4) ? 1 : 0))
        $display("FAIL fixed_%0d: got v=%b a=%h ch=%b want 1 %h", j, out_valid_f, out_addr_f, out_ch_f, ea);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (out_valid_f !== 1'b0 || busy_f !== 1'b0)
      $display("FAIL fixed_end: got v=%b b=%b want 0 0", out_valid_f, busy_f);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 2'b10;
      in_addr[53:27] = 27'h700 + 27'(k);
      @(posedge clk); #1;
    end
    in_valid = 2'b00;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_addr !== 27'h701)
      $display("FAIL mid_pre: got v=%b a=%h want 1 701", out_valid, out_addr);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 2'b00 ||
        out_addr !== 27'h0 || out_ch !== 1'b0)
      $display("FAIL mid_rst: got v=%b b=%b r=%b a=%h want 0 0 00 0", out_valid, busy, in_ready, out_addr);
    else n_pass++;
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL mid_discard: got emitted=%b want 0", seen);
    else n_pass++;
    n_chk++;
    if (in_ready !== 2'b11)
      $display("FAIL mid_ready: got %b want 11", in_ready);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0; in_addr = '0; in_data = '0; in_mask = '0;
    in_valid_f = '0; in_addr_f = '0; in_data_f = '0; in_mask_f = '0;
    out_ready = 1'b0; out_ready_f = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_drain();
    test_rr();
    test_fixed();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
